// File: rtl/lru_kv_cache_if.sv
// lru_kv_cache_if: request/response bus of the LRU key/value cache.
// The master drives requests and consumes responses; the slave is the cache.
// Optional statistics signals exist only when LRU_KV_CACHE_STATS_EN is defined.
interface lru_kv_cache_if #(
  parameter int KEY_W  = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int STAT_W = 16
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [KEY_W-1:0]  req_key;
  logic [DATA_W-1:0] req_data;
  logic              flush;
  logic              resp_valid;
  logic              resp_ready;
  logic              resp_hit;
  logic [DATA_W-1:0] resp_data;
  logic              evict_valid;
  logic [KEY_W-1:0]  evict_key;
  logic [DATA_W-1:0] evict_data;
  logic [CNT_W-1:0]  occupancy;
`ifdef LRU_KV_CACHE_STATS_EN
  logic [STAT_W-1:0] hit_cnt;
  logic [STAT_W-1:0] miss_cnt;
`endif

  modport master (
    output req_valid, req_wr, req_key, req_data, flush, resp_ready,
    input  req_ready, resp_valid, resp_hit, resp_data,
    input  evict_valid, evict_key, evict_data, occupancy
`ifdef LRU_KV_CACHE_STATS_EN
    , input hit_cnt, miss_cnt
`endif
  );

  modport slave (
    input  req_valid, req_wr, req_key, req_data, flush, resp_ready,
    output req_ready, resp_valid, resp_hit, resp_data,
    output evict_valid, evict_key, evict_data, occupancy
`ifdef LRU_KV_CACHE_STATS_EN
    , output hit_cnt, miss_cnt
`endif
  );
endinterface

// File: rtl/lru_kv_cache.sv
// lru_kv_cache: key/value cache with true-LRU ordering, MRU kept in slot 0.
// Hits move the entry to slot 0; write misses insert at slot 0 and push the
// LRU entry out of slot DEPTH-1. Single-register response stage.
// Optional feature macro: LRU_KV_CACHE_STATS_EN (hit/miss counters).
module lru_kv_cache #(
  parameter int KEY_W  = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int STAT_W = 16
) (
  input logic             clk,
  input logic             reset,
  lru_kv_cache_if.slave   bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Entry array, MRU first
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [KEY_W-1:0]  key_q  [DEPTH];
  logic [KEY_W-1:0]  key_d  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [CNT_W-1:0]  occ_q, occ_d;

  // Response stage
  logic              resp_valid_q, resp_valid_d;
  logic              resp_hit_q, resp_hit_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              evict_valid_q, evict_valid_d;
  logic [KEY_W-1:0]  evict_key_q, evict_key_d;
  logic [DATA_W-1:0] evict_data_q, evict_data_d;

  // Lookup results
  logic [DEPTH-1:0]  match_s;
  logic [DEPTH-1:0]  above_s;   // above_s[i]: hit slot index is >= i
  logic              hit_s;
  logic [DATA_W-1:0] hit_data_s;
  logic              req_ready_s;
  logic              accept_s;

  assign req_ready_s = ~resp_valid_q | bus.resp_ready;
  assign accept_s    = bus.req_valid & req_ready_s;
  assign hit_s       = |match_s;

  // Parallel key compare, hit-position mask and hit-data select
  always_comb begin
    match_s    = {DEPTH{1'b0}};
    above_s    = {DEPTH{1'b0}};
    hit_data_s = {DATA_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      match_s[i] = valid_q[i] & (key_q[i] == bus.req_key);
      hit_data_s = hit_data_s | (data_q[i] & {DATA_W{match_s[i]}});
    end
    above_s[DEPTH-1] = match_s[DEPTH-1];
    for (int i = DEPTH - 2; i >= 0; i--) begin
      above_s[i] = above_s[i+1] | match_s[i];
    end
  end

  // Next array contents: flush clears, hit rotates to front, write miss shifts in
  always_comb begin
    valid_d = valid_q;
    key_d   = key_q;
    data_d  = data_q;
    occ_d   = occ_q;
    if (bus.flush) begin
      // flush wins over a simultaneous request; keys/data may stay stale
      valid_d = {DEPTH{1'b0}};
      occ_d   = {CNT_W{1'b0}};
    end else if (accept_s && hit_s) begin
      for (int i = 1; i < DEPTH; i++) begin
        if (above_s[i]) begin
          valid_d[i] = valid_q[i-1];
          key_d[i]   = key_q[i-1];
          data_d[i]  = data_q[i-1];
        end else begin
          valid_d[i] = valid_q[i];
        end
      end
      valid_d[0] = 1'b1;
      key_d[0]   = bus.req_key;
      data_d[0]  = bus.req_wr ? bus.req_data : hit_data_s;
    end else if (accept_s && bus.req_wr) begin
      for (int i = 1; i < DEPTH; i++) begin
        valid_d[i] = valid_q[i-1];
        key_d[i]   = key_q[i-1];
        data_d[i]  = data_q[i-1];
      end
      valid_d[0] = 1'b1;
      key_d[0]   = bus.req_key;
      data_d[0]  = bus.req_data;
      // a free LRU slot means nothing is evicted, so one more entry is live
      if (!valid_q[DEPTH-1] && (occ_q != CNT_W'(DEPTH))) begin
        occ_d = occ_q + CNT_W'(1);
      end else begin
        occ_d = occ_q;
      end
    end else begin
      occ_d = occ_q;
    end
  end

  // Response beat: load on accept, clear when consumed, hold while stalled
  always_comb begin
    resp_valid_d  = resp_valid_q;
    resp_hit_d    = resp_hit_q;
    resp_data_d   = resp_data_q;
    evict_valid_d = evict_valid_q;
    evict_key_d   = evict_key_q;
    evict_data_d  = evict_data_q;
    if (accept_s) begin
      resp_valid_d  = 1'b1;
      resp_hit_d    = hit_s & ~bus.flush;
      resp_data_d   = (hit_s && !bus.req_wr && !bus.flush) ? hit_data_s : {DATA_W{1'b0}};
      evict_valid_d = bus.req_wr & ~hit_s & ~bus.flush & valid_q[DEPTH-1];
      evict_key_d   = evict_valid_d ? key_q[DEPTH-1]  : {KEY_W{1'b0}};
      evict_data_d  = evict_valid_d ? data_q[DEPTH-1] : {DATA_W{1'b0}};
    end else if (bus.resp_ready) begin
      resp_valid_d  = 1'b0;
      resp_hit_d    = 1'b0;
      resp_data_d   = {DATA_W{1'b0}};
      evict_valid_d = 1'b0;
      evict_key_d   = {KEY_W{1'b0}};
      evict_data_d  = {DATA_W{1'b0}};
    end else begin
      resp_valid_d  = resp_valid_q;
    end
  end

  // State and response registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q       <= {DEPTH{1'b0}};
      occ_q         <= {CNT_W{1'b0}};
      resp_valid_q  <= 1'b0;
      resp_hit_q    <= 1'b0;
      resp_data_q   <= {DATA_W{1'b0}};
      evict_valid_q <= 1'b0;
      evict_key_q   <= {KEY_W{1'b0}};
      evict_data_q  <= {DATA_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        key_q[i]  <= {KEY_W{1'b0}};
        data_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      valid_q       <= valid_d;
      occ_q         <= occ_d;
      resp_valid_q  <= resp_valid_d;
      resp_hit_q    <= resp_hit_d;
      resp_data_q   <= resp_data_d;
      evict_valid_q <= evict_valid_d;
      evict_key_q   <= evict_key_d;
      evict_data_q  <= evict_data_d;
      for (int i = 0; i < DEPTH; i++) begin
        key_q[i]  <= key_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  assign bus.req_ready   = req_ready_s;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_hit    = resp_hit_q;
  assign bus.resp_data   = resp_data_q;
  assign bus.evict_valid = evict_valid_q;
  assign bus.evict_key   = evict_key_q;
  assign bus.evict_data  = evict_data_q;
  assign bus.occupancy   = occ_q;

`ifdef LRU_KV_CACHE_STATS_EN
  logic [STAT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [STAT_W-1:0] miss_cnt_q, miss_cnt_d;

  // Saturating hit/miss counters; a request accepted with flush is a miss
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (accept_s && hit_s && !bus.flush) begin
      hit_cnt_d = (hit_cnt_q != {STAT_W{1'b1}}) ? hit_cnt_q + STAT_W'(1) : hit_cnt_q;
    end else if (accept_s) begin
      miss_cnt_d = (miss_cnt_q != {STAT_W{1'b1}}) ? miss_cnt_q + STAT_W'(1) : miss_cnt_q;
    end else begin
      hit_cnt_d = hit_cnt_q;
    end
  end

  // Counter registers; only reset clears them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt_q  <= {STAT_W{1'b0}};
      miss_cnt_q <= {STAT_W{1'b0}};
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign bus.hit_cnt  = hit_cnt_q;
  assign bus.miss_cnt = miss_cnt_q;
`else
`endif
endmodule

// File: tb/tb_lru_kv_cache.sv
// tb_lru_kv_cache: directed plus randomized bench for lru_kv_cache (DEPTH=4).
// A queue-based LRU list model predicts each response; a monitor pops and
// compares whenever the cache presents a response beat.
module tb_lru_kv_cache;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lru_kv_cache_if #(.KEY_W(8), .DATA_W(8), .DEPTH(DEPTH), .STAT_W(16)) bus ();

  lru_kv_cache #(.KEY_W(8), .DATA_W(8), .DEPTH(DEPTH), .STAT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       hit;
    logic [7:0] data;
    logic       ev;
    logic [7:0] ek;
    logic [7:0] ed;
    int         stamp;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sbq[$];
  logic [7:0] mk[$];   // model keys, MRU first
  logic [7:0] md[$];   // model data, parallel to mk
  logic pend = 1'b0;   // model: a response beat is outstanding
  int   hits = 0;
  int   misses = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic drive(input logic v, input logic wr, input logic [7:0] k,
                       input logic [7:0] d, input logic fl, input logic rr);
    @(posedge clk);
    #1;
    bus.req_valid  = v;
    bus.req_wr     = wr;
    bus.req_key    = k;
    bus.req_data   = d;
    bus.flush      = fl;
    bus.resp_ready = rr;
  endtask

  initial begin : cycle_count
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Reference model: LRU list kept as queues, updated once per cycle
  initial begin : model
    logic       acc;
    int         idx;
    logic [7:0] nd;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (reset) begin
        mk.delete();
        md.delete();
        pend   = 1'b0;
        hits   = 0;
        misses = 0;
      end else begin
        chk("occupancy", 32'(bus.occupancy), 32'(mk.size()));
        chk("req_ready", 32'(bus.req_ready), 32'(!pend || bus.resp_ready));
`ifdef LRU_KV_CACHE_STATS_EN
        chk("hit_cnt", 32'(bus.hit_cnt), 32'(hits));
        chk("miss_cnt", 32'(bus.miss_cnt), 32'(misses));
`endif
        acc = bus.req_valid && (!pend || bus.resp_ready);
        e.hit = 1'b0; e.data = 8'h00; e.ev = 1'b0; e.ek = 8'h00; e.ed = 8'h00; e.stamp = cyc;
        if (acc) begin
          if (bus.flush) begin
            mk.delete();
            md.delete();
            if (misses != 65535) misses++;
          end else begin
            idx = -1;
            foreach (mk[i]) if (mk[i] == bus.req_key) idx = i;
            if (idx >= 0) begin
              e.hit = 1'b1;
              if (!bus.req_wr) e.data = md[idx];
              nd = bus.req_wr ? bus.req_data : md[idx];
              mk.delete(idx);
              md.delete(idx);
              mk.push_front(bus.req_key);
              md.push_front(nd);
              if (hits != 65535) hits++;
            end else begin
              if (misses != 65535) misses++;
              if (bus.req_wr) begin
                mk.push_front(bus.req_key);
                md.push_front(bus.req_data);
                if (mk.size() > DEPTH) begin
                  e.ev = 1'b1;
                  e.ek = mk.pop_back();
                  e.ed = md.pop_back();
                end
              end
            end
          end
          sbq.push_back(e);
        end else if (bus.flush) begin
          mk.delete();
          md.delete();
        end
        pend = acc || (pend && !bus.resp_ready);
      end
    end
  end

  // Monitor: compare each presented response beat against the scoreboard
  initial begin : monitor
    exp_t f;
    forever begin
      @(negedge clk);
      if (reset) begin
        sbq.delete();
      end else if (sbq.size() > 0 && sbq[0].stamp < cyc) begin
        f = sbq[0];
        chk("resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("resp_hit", 32'(bus.resp_hit), 32'(f.hit));
        chk("resp_data", 32'(bus.resp_data), 32'(f.data));
        chk("evict_valid", 32'(bus.evict_valid), 32'(f.ev));
        chk("evict_key", 32'(bus.evict_key), 32'(f.ek));
        chk("evict_data", 32'(bus.evict_data), 32'(f.ed));
        if (bus.resp_ready) void'(sbq.pop_front());
      end else begin
        chk("resp_idle", 32'(bus.resp_valid), 32'd0);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Stimulus: directed scenarios followed by randomized traffic
  initial begin : stim
    bus.req_valid  = 1'b0;
    bus.req_wr     = 1'b0;
    bus.req_key    = 8'h00;
    bus.req_data   = 8'h00;
    bus.flush      = 1'b0;
    bus.resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_hit", 32'(bus.resp_hit), 32'd0);
    chk("rst_resp_data", 32'(bus.resp_data), 32'd0);
    chk("rst_evict_valid", 32'(bus.evict_valid), 32'd0);
    chk("rst_evict_key", 32'(bus.evict_key), 32'd0);
    chk("rst_evict_data", 32'(bus.evict_data), 32'd0);
    chk("rst_occupancy", 32'(bus.occupancy), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;

    // read on empty cache
    drive(1'b1, 1'b0, 8'h11, 8'h00, 1'b0, 1'b1);
    // fill, then hit the oldest entry
    drive(1'b1, 1'b1, 8'h11, 8'hA1, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 8'h22, 8'hA2, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 8'h33, 8'hA3, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 8'h44, 8'hA4, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 8'h11, 8'h00, 1'b0, 1'b1);
    // eviction of 0x22, then miss on it
    drive(1'b1, 1'b1, 8'h55, 8'hA5, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 8'h22, 8'h00, 1'b0, 1'b1);
    // write hit then read back
    drive(1'b1, 1'b1, 8'h33, 8'hB3, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 8'h33, 8'h00, 1'b0, 1'b1);
    // response stall for 3 cycles with a waiting request, then release
    drive(1'b1, 1'b0, 8'h44, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 8'h55, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'h55, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'h55, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'h55, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    // flush together with an accepted write
    drive(1'b1, 1'b1, 8'h66, 8'hA6, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 8'h66, 8'h00, 1'b0, 1'b1);
    // flush while a response is stalled keeps the beat
    drive(1'b1, 1'b1, 8'h77, 8'hA7, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    // reset with a response pending
    drive(1'b1, 1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("midrst_occupancy", 32'(bus.occupancy), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // randomized traffic on a small key space to force hits and evictions
    for (int n = 0; n < 800; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 7)), 8'($urandom), 1'($urandom_range(0, 39) == 0),
            1'($urandom_range(0, 3) != 0));
    end
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    repeat (4) drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    chk("drain", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
